// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and stall/flush controls.
//   master : pipeline / test driver (drives ID/EX snapshot, mc start, flush)
//   slave  : hazard_ctrl (drives enables, bubbles, flushes, busy, stall count)
interface hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic [REG_ADDR_W-1:0] if_id_rs1;
   logic [REG_ADDR_W-1:0] if_id_rs2;
   logic                  if_id_rs1_used;
   logic                  if_id_rs2_used;
   logic [REG_ADDR_W-1:0] id_ex_rd;
   logic                  id_ex_mem_read;
   logic                  ex_mc_start;
   logic                  flush;

   logic                  pc_write_en;
   logic                  if_id_write_en;
   logic                  id_ex_bubble;
   logic                  id_ex_write_en;
   logic                  ex_mem_bubble;
   logic                  if_id_flush;
   logic                  id_ex_flush;
   logic                  busy;
   logic [CNT_W-1:0]      stall_cycles;

   modport master (
      output if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used,
             id_ex_rd, id_ex_mem_read, ex_mc_start, flush,
      input  pc_write_en, if_id_write_en, id_ex_bubble, id_ex_write_en,
             ex_mem_bubble, if_id_flush, id_ex_flush, busy, stall_cycles
   );

   modport slave (
      input  if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used,
             id_ex_rd, id_ex_mem_read, ex_mc_start, flush,
      output pc_write_en, if_id_write_en, id_ex_bubble, id_ex_write_en,
             ex_mem_bubble, if_id_flush, id_ex_flush, busy, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use detection with
// configurable load latency, multi-cycle EX stall, branch-flush override and a
// saturating stall-cycle counter.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   hz    : hazard_ctrl_if.slave (hazard inputs in, pipeline controls out)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no wait pending; detector evaluates hazards every cycle
// LOAD_WAIT | remaining cycles of a multi-cycle load-use stall
// MC_BUSY   | remaining cycles of a multi-cycle EX op (mul/div)
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1,
   parameter int MC_LAT     = 4,
   parameter int CNT_W      = 32
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);

   localparam int MAX_LAT = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   localparam logic [CW-1:0]         LOAD_INIT = CW'(LOAD_LAT - 1);
   localparam logic [CW-1:0]         MC_INIT   = CW'(MC_LAT - 2);
   localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
   localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      MC_BUSY   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q;

   logic lu_hit;
   logic pc_we, if_id_we, id_ex_we, id_ex_bub, ex_mem_bub, flush_o;

   // Unused source fields never match, and x0 never creates a dependency.
   assign lu_hit = hz.id_ex_mem_read && (hz.id_ex_rd != ZERO_REG) &&
                   ((hz.if_id_rs1_used && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                    (hz.if_id_rs2_used && (hz.if_id_rs2 == hz.id_ex_rd)));

   // Controls must act in the detection cycle, so they decode combinationally
   // from the registered state and the current inputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_we      = 1'b1;
      if_id_we   = 1'b1;
      id_ex_we   = 1'b1;
      id_ex_bub  = 1'b0;
      ex_mem_bub = 1'b0;
      flush_o    = 1'b0;

      if (hz.flush) begin
         flush_o = 1'b1;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hz.ex_mc_start) begin
                  pc_we      = 1'b0;
                  if_id_we   = 1'b0;
                  id_ex_we   = 1'b0;
                  ex_mem_bub = 1'b1;
                  if (MC_LAT > 2) begin
                     state_d = MC_BUSY;
                     cnt_d   = MC_INIT;
                  end
               end else if (lu_hit) begin
                  pc_we     = 1'b0;
                  if_id_we  = 1'b0;
                  id_ex_bub = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = LOAD_WAIT;
                     cnt_d   = LOAD_INIT;
                  end
               end
            end
            LOAD_WAIT: begin
               pc_we     = 1'b0;
               if_id_we  = 1'b0;
               id_ex_bub = 1'b1;
               cnt_d     = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_d = IDLE;
            end
            MC_BUSY: begin
               pc_we      = 1'b0;
               if_id_we   = 1'b0;
               id_ex_we   = 1'b0;
               ex_mem_bub = 1'b1;
               cnt_d      = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (!pc_we && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
      end
   end

   assign hz.pc_write_en    = pc_we;
   assign hz.if_id_write_en = if_id_we;
   assign hz.id_ex_write_en = id_ex_we;
   assign hz.id_ex_bubble   = id_ex_bub;
   assign hz.ex_mem_bubble  = ex_mem_bub;
   assign hz.if_id_flush    = flush_o;
   assign hz.id_ex_flush    = flush_o;
   assign hz.busy           = (state_q != IDLE);
   assign hz.stall_cycles   = stall_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard/stall controller for the 5-stage pipeline. It is the next generation of the load-use detector.
- Adds three things the single-cycle detector lacked:
  - configurable load-to-use latency, for multi-cycle data memory;
  - a multi-cycle EX unit stall (mul/div);
  - branch-flush override, plus a saturating stall-cycle performance counter.
- Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and bubble controls.

Parameters:
- REG_ADDR_W, 5, register-address width.
- LOAD_LAT, 1, total stall cycles per load-use hazard. Must be >=1; 1 gives classic single-bubble behaviour.
- MC_LAT, 4, cycles a multi-cycle op occupies EX. Must be >=2.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IF_ID_Rs1  in  REG_ADDR_W  source 1 of instruction in ID.
- IF_ID_Rs2  in  REG_ADDR_W  source 2 of instruction in ID.
- IF_ID_Rs1_Used  in  1  instruction in ID reads Rs1.
- IF_ID_Rs2_Used  in  1  instruction in ID reads Rs2.
- ID_EX_Rd  in  REG_ADDR_W  destination of instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_MC_Start  in  1  single-cycle pulse: multi-cycle op has entered EX.
- Flush  in  1  taken branch/jump resolved; squash younger stages.
- PC_Write_En  out  1  PC may update.
- IF_ID_Write_En  out  1  IF/ID may update.
- ID_EX_Bubble  out  1  load NOP into ID/EX.
- ID_EX_Write_En  out  1  ID/EX may update (0 holds the multi-cycle op in EX).
- EX_MEM_Bubble  out  1  load NOP into EX/MEM.
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.
- Busy  out  1  state != IDLE.
- StallCycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Rst low (async): state=IDLE, cnt=0, StallCycles=0. Outputs then follow IDLE decoding.
- Idle outputs (no hazard, no flush): all enables 1, all bubbles/flushes 0, Busy=0.
- lu_hit (combinational):
  - ID_EX_MemRead && ID_EX_Rd!=0;
  - AND either (Rs1_Used && Rs1==Rd) or (Rs2_Used && Rs2==Rd).
  - Unused source fields never match.
- States: IDLE, LOAD_WAIT, MC_BUSY. cnt is an internal down-counter sized to max(LOAD_LAT, MC_LAT).
- Priority: Flush > multi-cycle > load-use.
- IDLE:
  - EX_MC_Start=1: PC_Write_En=0, IF_ID_Write_En=0, ID_EX_Write_En=0, EX_MEM_Bubble=1. If MC_LAT>2, next state MC_BUSY with cnt=MC_LAT-2; otherwise stay IDLE.
  - Else lu_hit=1: PC_Write_En=0, IF_ID_Write_En=0, ID_EX_Bubble=1. If LOAD_LAT>1, next state LOAD_WAIT with cnt=LOAD_LAT-1; otherwise stay IDLE.
- LOAD_WAIT:
  - PC/IF_ID held, ID_EX_Bubble=1.
  - cnt decrements each cycle; cnt==1 -> IDLE.
  - lu_hit is ignored in this state.
- MC_BUSY:
  - PC, IF_ID and ID_EX held; EX_MEM_Bubble=1.
  - cnt decrements; cnt==1 -> IDLE.
  - EX_MC_Start is ignored in this state.
- Resulting stall lengths:
  - Load-use: exactly LOAD_LAT consecutive cycles.
  - Multi-cycle: exactly MC_LAT-1 cycles.
  - Both are counted from the detection cycle.
- Flush=1 in any state:
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write_En=1, IF_ID_Write_En=1, ID_EX_Write_En=1, all bubbles 0.
  - Next state IDLE, cnt=0. This aborts any wait.
- Back-to-back: returning to IDLE, the detector re-evaluates the same cycle, so a new hazard in the first IDLE cycle stalls immediately.
- StallCycles increments by 1 on each rising edge where PC_Write_En==0. It saturates at all-ones and does not wrap. It is cleared only by reset.
- Reset mid-wait: returns to IDLE immediately (async), with no residual stall.

Test Plan:
- Load-use, LOAD_LAT=1:
  - Stimulus: ID_EX_MemRead=1, ID_EX_Rd=5, Rs1=5, Rs1_Used=1 for 1 cycle, then MemRead=0.
  - Required: PC_Write_En=0 and ID_EX_Bubble=1 for exactly 1 cycle; StallCycles=1.
- LOAD_LAT=3, same hazard:
  - Required: stall for 3 cycles (Busy=1 on cycles 2-3), then IDLE.
  - Also: Rd=0 or Rs2 match with Rs2_Used=0 -> no stall.
- MC_LAT=4, EX_MC_Start pulse:
  - Required: ID_EX_Write_En=0 and EX_MEM_Bubble=1 for 3 cycles, then all enables 1.
  - Same pulse with lu_hit=1 simultaneously -> multi-cycle behaviour only, ID_EX_Bubble=0.
- Flush during LOAD_WAIT, LOAD_LAT=4:
  - Stimulus: Flush=1 on the 2nd stall cycle.
  - Required: that cycle both flushes=1 and PC_Write_En=1; next cycle IDLE; StallCycles=1.
- Saturation and reset:
  - Stimulus: CNT_W=3, 9 consecutive stall cycles.
  - Required: StallCycles holds at 7.
  - Then assert rst low mid-MC_BUSY -> Busy=0 and StallCycles=0 without a clock edge.
